// File: rtl/traffic_car_queue.sv
// Vehicle-side queue model for the two-way traffic light controller: counts arrivals per approach,
// raises EWCar/NSCar and releases queued cars while green. Optional stats via TRAFFIC_QUEUE_STATS_EN.

module traffic_car_queue_lane #(
    parameter int CNT_W         = 4,
    parameter int DEPART_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arrive,
    input  logic             light,
    output logic [CNT_W-1:0] count,
    output logic             depart,
    output logic             drop
);
    typedef enum logic [1:0] {IDLE, WAIT, SERVE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [7:0]       TIMER_LAST = 8'(DEPART_CYCLES - 1);

    state_t           state, state_next;
    logic [7:0]       timer, timer_next;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            timer <= 8'd0;
            count <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            count <= count_next;
        end
    end

    // The timer only runs on SERVE edges with the light still green; every other edge clears it.
    always_comb begin
        state_next = state;
        timer_next = 8'd0;
        count_next = count;
        depart     = 1'b0;
        drop       = 1'b0;

        if (state == SERVE && light) begin
            if (timer == TIMER_LAST) depart = 1'b1;
            else                     timer_next = timer + 8'd1;
        end

        if (arrive && !depart) begin
            if (count == CNT_MAX) drop = 1'b1;
            else                  count_next = count + 1'b1;
        end else if (!arrive && depart) begin
            count_next = count - 1'b1;
        end

        case (state)
            IDLE:    if (arrive) state_next = light ? SERVE : WAIT;
            WAIT:    if (light) state_next = SERVE;
            SERVE: begin
                if (!light)                 state_next = WAIT;
                else if (count_next == '0)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

module traffic_car_queue #(
    parameter int CNT_W         = 4,
    parameter int DEPART_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ew_arrive,
    input  logic             ns_arrive,
    input  logic             EWLite,
    input  logic             NSLite,
    output logic             EWCar,
    output logic             NSCar,
    output logic [CNT_W-1:0] ew_count,
    output logic [CNT_W-1:0] ns_count,
    output logic             overflow,
    output logic             conflict
`ifdef TRAFFIC_QUEUE_STATS_EN
    ,
    output logic [15:0]      ew_served,
    output logic [15:0]      ns_served,
    output logic [CNT_W-1:0] max_ew_q,
    output logic [CNT_W-1:0] max_ns_q
`endif
);
    logic ew_depart, ns_depart, ew_drop, ns_drop;

    traffic_car_queue_lane #(.CNT_W(CNT_W), .DEPART_CYCLES(DEPART_CYCLES)) u_ew (
        .clock(clock), .reset(reset), .arrive(ew_arrive), .light(EWLite),
        .count(ew_count), .depart(ew_depart), .drop(ew_drop)
    );

    traffic_car_queue_lane #(.CNT_W(CNT_W), .DEPART_CYCLES(DEPART_CYCLES)) u_ns (
        .clock(clock), .reset(reset), .arrive(ns_arrive), .light(NSLite),
        .count(ns_count), .depart(ns_depart), .drop(ns_drop)
    );

    assign EWCar = (ew_count != '0);
    assign NSCar = (ns_count != '0);

    // Both flags are sticky until reset so a system bench can inspect them at the end of a run.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            conflict <= 1'b0;
        end else begin
            overflow <= overflow | ew_drop | ns_drop;
            conflict <= conflict | (EWLite & NSLite);
        end
    end

`ifdef TRAFFIC_QUEUE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ew_served <= 16'd0;
            ns_served <= 16'd0;
            max_ew_q  <= '0;
            max_ns_q  <= '0;
        end else begin
            if (ew_depart) ew_served <= ew_served + 16'd1;
            if (ns_depart) ns_served <= ns_served + 16'd1;
            if (ew_count > max_ew_q) max_ew_q <= ew_count;
            if (ns_count > max_ns_q) max_ns_q <= ns_count;
        end
    end
`endif
endmodule

// File: doc/traffic_car_queue.md
Name: traffic_car_queue

Overview:
- Vehicle-side counterpart of the two-way traffic light controller.
- Counts cars arriving on the EW and NS approaches and drives the EWCar/NSCar request lines into the controller.
- Consumes the controller's EWLite/NSLite outputs and releases one queued car every DEPART_CYCLES cycles while that direction is green.
- Used as the intersection model in system benches, and as the request generator when real detectors are pulse-based.

Parameters:
- CNT_W, 4: width of each per-direction queue counter; max queue is 2^CNT_W-1.
- DEPART_CYCLES, 2: green cycles needed per departing car; legal range is 1 to 255.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- ew_arrive  in  1  one-cycle pulse: one car arrives on the EW approach.
- ns_arrive  in  1  one-cycle pulse: one car arrives on the NS approach.
- EWLite  in  1  from the controller; 1 means EW is green.
- NSLite  in  1  from the controller; 1 means NS is green.
- EWCar  out  1  EW request; 1 while ew_count != 0.
- NSCar  out  1  NS request; 1 while ns_count != 0.
- ew_count  out  CNT_W  cars currently queued on EW.
- ns_count  out  CNT_W  cars currently queued on NS.
- overflow  out  1  sticky; set when an arrival is dropped at a full queue.
- conflict  out  1  sticky; set when EWLite and NSLite are both 1 on a clock edge.

Behaviour:
- Reset (synchronous, active-high, wins over every other input):
  - Both counts and both departure timers are 0; both FSMs go to IDLE.
  - overflow=0, conflict=0, EWCar=0, NSCar=0 on the first cycle after the reset edge.
  - Asserting reset mid-service discards queued cars and any partial timer.
- Per-direction FSM (EW and NS are identical and independent). Light means EWLite for EW, NSLite for NS.
  - IDLE: count=0. An arrival goes to WAIT if the light is 0, or to SERVE if the light is 1.
  - WAIT: count>0 and light=0. Timer is held at 0. Goes to SERVE on the first edge where light=1.
  - SERVE: count>0 and light=1. Timer increments each edge.
    - When the timer equals DEPART_CYCLES-1, count decrements and the timer clears to 0.
    - light=0 goes to WAIT, timer clears, no decrement on that edge.
    - A decrement that brings count to 0 goes to IDLE.
- Count arithmetic, per edge: next = count + arrive - depart.
  - Arrive and depart on the same edge: count unchanged.
  - Arrive with count at max and no depart: count holds at max, the arrival is dropped, overflow is set.
  - A depart is never generated when count=0, so there is no underflow.
- Outputs:
  - EWCar and NSCar are a combinational compare of the registered count.
  - Latency: an arrival pulse sampled on edge k raises the request after edge k (visible in cycle k+1).
- The two lights are not cross-checked for service: each direction serves whenever its own light is 1. Both lights at 1 also sets conflict; it clears only on reset.
- The controller's initial state makes NSLite=1, so queued NS cars drain immediately after reset.

Optional Feature:
- Macro: TRAFFIC_QUEUE_STATS_EN.
- Defined:
  - Adds outputs ew_served and ns_served, 16 bits each, reset to 0.
  - Each increments on every departure edge of its direction and wraps at 0xFFFF to 0.
  - Adds output max_ew_q and max_ns_q, CNT_W bits each: high-water marks of the counts, reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-service: 3 EW cars queued, EWLite=1, reset pulsed for 1 cycle → next cycle ew_count=0, EWCar=0, overflow=0, and no late decrement occurs.
- Basic service: DEPART_CYCLES=2, 3 EW arrivals while EWLite=0 → ew_count=3, EWCar=1. Then EWLite=1 → count reads 2, 1, 0 at 2-cycle intervals, and EWCar=0 the cycle after the last decrement.
- Simultaneous events: ns_count=2, NSLite=1, ns_arrive pulsed on the departure edge → ns_count stays 2, timer restarts, NSCar stays 1.
- Saturation: CNT_W=4, 16 NS arrivals with NSLite=0 → ns_count=15, overflow=1 after the 16th, and overflow stays 1 after the queue later drains.
- Light drop mid-timer: DEPART_CYCLES=3, ew_count=1, EWLite=1 for 2 cycles then 0 → no decrement, state WAIT. EWLite=1 again → the decrement lands 3 cycles later.
- Conflict and stats: drive EWLite=NSLite=1 for one cycle → conflict=1 and both queues are served. With TRAFFIC_QUEUE_STATS_EN defined, ew_served and ns_served each equal the number of departures and max_ew_q matches the peak count.
